// File: rtl/serializer32_pkg.sv
// Shared types and constants for the 32-bit serializer.
// SERIALIZER32_PARITY_EN adds an even-parity trailer beat to every frame.
package serializer32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH + 2);

`ifdef SERIALIZER32_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/serializer32_if.sv
// Parallel word input and serial bit output handshakes of serializer32.
// The slave modport is the serializer, the master modport is its environment.
interface serializer32_if;
  import serializer32_pkg::*;

  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic             so;
  logic             so_valid;
  logic             so_ready;
  logic             so_first;
  logic             so_last;
  logic             busy;

  modport slave (
    input  d, in_valid, so_ready,
    output in_ready, so, so_valid, so_first, so_last, busy
  );

  modport master (
    output d, in_valid, so_ready,
    input  in_ready, so, so_valid, so_first, so_last, busy
  );

endinterface

// File: rtl/piso_shreg32.sv
// Load/shift register whose MSB is the bit currently on the serial line.
// With SERIALIZER32_PARITY_EN the parity of the loaded word is shifted in at the bottom.
module piso_shreg32
  import serializer32_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             fill_bit;

`ifdef SERIALIZER32_PARITY_EN
  logic par_q, par_d;

  // After WIDTH shifts the MSB holds the parity bit, ready for the trailer beat.
  assign fill_bit = par_q;

  always_comb begin
    par_d = par_q;
    if (load_i) begin
      par_d = ^data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign fill_bit = 1'b0;
`endif

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[WIDTH-2:0], fill_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/serializer32.sv
// MSB-first parallel-to-serial transmitter for 32-bit words.
// Define SERIALIZER32_PARITY_EN to append an even-parity trailer beat.
module serializer32
  import serializer32_pkg::*;
(
  input logic           clk,
  input logic           reset_n,
  serializer32_if.slave bus
);

  state_e state_q;
  cnt_t   cnt_q;
  logic   so_valid_q;
  logic   so_first_q;
  logic   so_last_q;
  logic   accept;
  logic   beat;
  logic   so_bit;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign beat   = so_valid_q && bus.so_ready;

  piso_shreg32 u_shreg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (accept),
    .shift_i (beat),
    .data_i  (bus.d),
    .msb_o   (so_bit)
  );

  // cnt_q numbers the beat currently presented on so, starting at 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      so_valid_q <= 1'b0;
      so_first_q <= 1'b0;
      so_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_SHIFT;
            cnt_q      <= cnt_t'(1);
            so_valid_q <= 1'b1;
            so_first_q <= 1'b1;
            so_last_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (beat) begin
            so_first_q <= 1'b0;
            if (cnt_q == cnt_t'(WIDTH)) begin
`ifdef SERIALIZER32_PARITY_EN
              state_q   <= ST_PARITY;
              cnt_q     <= cnt_q + cnt_t'(1);
              so_last_q <= 1'b1;
`else
              state_q    <= ST_IDLE;
              cnt_q      <= '0;
              so_valid_q <= 1'b0;
              so_last_q  <= 1'b0;
`endif
            end else begin
              cnt_q     <= cnt_q + cnt_t'(1);
              so_last_q <= (cnt_q + cnt_t'(1)) == cnt_t'(FRAME_LEN);
            end
          end
        end
`ifdef SERIALIZER32_PARITY_EN
        ST_PARITY: begin
          if (beat) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            so_valid_q <= 1'b0;
            so_last_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          so_valid_q <= 1'b0;
          so_first_q <= 1'b0;
          so_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.so       = so_bit;
  assign bus.so_valid = so_valid_q;
  assign bus.so_first = so_first_q;
  assign bus.so_last  = so_last_q;

endmodule

// File: doc/serializer32.md
# serializer32

Parallel-in, serial-out transmitter for 32-bit words. It accepts one word per valid/ready handshake and emits it MSB-first, one bit per accepted beat, on a serial valid/ready interface. It is the outbound end of the word-register datapath: it feeds 32-bit register contents to a serial link, paired with the deserializer on the far side. An optional even-parity trailer bit can be compiled in.

## Interface
- WIDTH, 32, data word width; all behaviour below is stated for 32.
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- d  input  WIDTH  parallel word to transmit.
- in_valid  input  1  d is valid.
- in_ready  output  1  serializer can accept a word; high only in IDLE.
- so  output  1  serial data bit.
- so_valid  output  1  so is valid.
- so_ready  input  1  downstream accepts the current bit.
- so_first  output  1  high with the first bit of a frame, d[31].
- so_last  output  1  high with the final beat of a frame.
- busy  output  1  frame in progress; the inverse of in_ready.

## Operation
- **States:** IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- **Reset** (reset_n low at an edge):
  - State goes to IDLE; shift register and beat counter clear.
  - so, so_valid, so_first, so_last and busy go to 0; in_ready goes to 1.
  - A reset mid-frame aborts the frame. No remaining bits are emitted and nothing is resumed.
- **IDLE:**
  - in_ready=1, so_valid=0.
  - An edge with in_valid=1 is an accept. At that edge:
    - d is loaded.
    - so←d[31], so_valid←1, so_first←1.
    - Counter←1, state←SHIFT.
  - in_valid=0 stays in IDLE.
- **SHIFT:**
  - A beat completes on an edge with so_valid && so_ready. At that edge the next bit moves to so, so_first←0, and the counter increments.
  - While so_ready=0, so, so_first and so_last hold and the counter does not advance.
  - so_last=1 while the bit on so is d[0] (no parity build).
  - When the d[0] beat completes:
    - With the macro: go to PARITY.
    - Without the macro: go to IDLE with so_valid←0.
  - in_valid is ignored in SHIFT and PARITY. d is not re-sampled mid-frame.
- **PARITY:**
  - so = ^d of the loaded word (even parity); so_last=1.
  - When the beat completes: go to IDLE with so_valid←0.
- **Outputs:** all outputs are registered. in_ready and busy decode directly from the state register.

## Timing
- **Accept:** accept at edge k puts d[31] on so from edge k to edge k+1.
- **Zero stall:** d[31−n] is on so in cycle n+1 after the accept edge. d[0] is in cycle 32.
- **Throughput, no stall:** next accept at edge k+33 (32 data beats plus 1 IDLE cycle). With parity it is edge k+34.
- **Stall:** each cycle with so_ready=0 adds exactly one cycle and loses no bits.
- **so_ready in IDLE:** ignored.
- **Idle gap:** there is no back-to-back frame without the one-cycle IDLE gap.

## Configuration
- **SERIALIZER32_PARITY_EN defined:**
  - PARITY state present; 33 beats per frame.
  - so_last on the parity beat, not on d[0].
- **SERIALIZER32_PARITY_EN undefined:**
  - PARITY state and logic absent; 32 beats per frame.
  - so_last on d[0].

## Structure
- **Package serializer32_pkg:**
  - State encoding (IDLE, SHIFT, PARITY).
  - WIDTH default constant.
  - Counter width $clog2(WIDTH+2).
  - Frame-length constant (WIDTH, or WIDTH+1 with parity).
- **Sub-module piso_shreg32:**
  - Load/shift datapath: load, shift enable, MSB out.
  - Parity computed at load and held.
- **Top level:** the state machine, counter and output flags stay in the top level.

## Test plan
- **Reset:** reset_n=0 for 2 edges, mid-frame of 32'h12345678 → next cycle so_valid=0, so=0, in_ready=1. A following word transmits from its own bit 31.
- **Single frame, so_ready=1:** load 32'h12345678 → so sequence begins 0,0,0,1,0,0,1,0 and ends 1,0,0,0. Check:
  - so_first only on beat 1.
  - so_last only on beat 32 (no parity).
  - in_ready high again 33 cycles after the accept.
- **Backpressure:** 32'hFFEEDDCC with so_ready low for 3 cycles at beat 5 → beat-5 bit (1) held for 4 cycles, full 32-bit stream intact, frame takes 36 cycles.
- **Parity build:**
  - 32'h12345678 → 33rd beat so=1 with so_last.
  - 32'hFFEEDDCC → 33rd beat so=0.
- **Ignored input:** in_valid held high with d changing to 32'hBBAA9988 during a 32'h98765432 frame → the stream equals 32'h98765432 exactly. 32'hBBAA9988 is accepted on the first IDLE edge.
- **Back-to-back:** in_valid continuously high with 32'h00000000 then 32'hFFFFFFFF → 32 zeros, one idle cycle (so_valid=0), then 32 ones.
